// File: rtl/mcp_mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the unified MCP memory.
// Each grant runs a fixed IDLE -> ACCESS -> RESP sequence; read data is held per port.
module mcp_mem_arbiter #(
    parameter int WL = 32,
    parameter int AL = 9
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          A_REQ,
    input  logic          A_WE,
    input  logic [AL-1:0] A_ADDR,
    input  logic [WL-1:0] A_WD,
    output logic          A_ACK,
    output logic [WL-1:0] A_RD,
    input  logic          B_REQ,
    input  logic          B_WE,
    input  logic [AL-1:0] B_ADDR,
    input  logic [WL-1:0] B_WD,
    output logic          B_ACK,
    output logic [WL-1:0] B_RD,
    output logic          MWE,
    output logic [AL-1:0] MRA,
    output logic [WL-1:0] MWD,
    input  logic [WL-1:0] MRD
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    state_t          state_r;
    state_t          state_s;
    logic            owner_r;
    logic            last_gnt_r;
    logic            we_r;
    logic [AL-1:0]   mra_r;
    logic [WL-1:0]   mwd_r;
    logic            a_ack_r;
    logic            b_ack_r;
    logic [WL-1:0]   a_rd_r;
    logic [WL-1:0]   b_rd_r;

    logic            grant_s;
    logic            grant_b_s;
    logic            sel_we_s;
    logic [AL-1:0]   sel_addr_s;
    logic [WL-1:0]   sel_wd_s;

    // Arbitration: on a tie the port that did not win last time is granted.
    always_comb begin
        grant_s   = 1'b0;
        grant_b_s = 1'b0;
        if (A_REQ && B_REQ) begin
            grant_s   = 1'b1;
            grant_b_s = (last_gnt_r == OWN_A);
        end else if (A_REQ) begin
            grant_s   = 1'b1;
            grant_b_s = 1'b0;
        end else if (B_REQ) begin
            grant_s   = 1'b1;
            grant_b_s = 1'b1;
        end else begin
            grant_s   = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Request mux selecting the granted port's transaction fields.
    always_comb begin
        sel_we_s   = 1'b0;
        sel_addr_s = {AL{1'b0}};
        sel_wd_s   = {WL{1'b0}};
        if (grant_b_s) begin
            sel_we_s   = B_WE;
            sel_addr_s = B_ADDR;
            sel_wd_s   = B_WD;
        end else begin
            sel_we_s   = A_WE;
            sel_addr_s = A_ADDR;
            sel_wd_s   = A_WD;
        end
    end

    // Next-state logic for the three-phase access sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_s = ST_RESP;
            ST_RESP:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Transaction latch; fields are captured only at the grant edge.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            owner_r    <= OWN_A;
            last_gnt_r <= OWN_B;
            we_r       <= 1'b0;
            mra_r      <= {AL{1'b0}};
            mwd_r      <= {WL{1'b0}};
        end else if ((state_r == ST_IDLE) && grant_s) begin
            owner_r    <= grant_b_s;
            last_gnt_r <= grant_b_s;
            we_r       <= sel_we_s;
            mra_r      <= sel_addr_s;
            mwd_r      <= sel_wd_s;
        end
    end

    // Completion pulses, raised for the single RESP cycle of the owner.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            a_ack_r <= 1'b0;
            b_ack_r <= 1'b0;
        end else begin
            a_ack_r <= (state_r == ST_ACCESS) && (owner_r == OWN_A);
            b_ack_r <= (state_r == ST_ACCESS) && (owner_r == OWN_B);
        end
    end

    // Per-port read data, captured at the end of a read ACCESS cycle.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            a_rd_r <= {WL{1'b0}};
            b_rd_r <= {WL{1'b0}};
        end else if ((state_r == ST_ACCESS) && !we_r) begin
            if (owner_r == OWN_B) begin
                b_rd_r <= MRD;
            end else begin
                a_rd_r <= MRD;
            end
        end
    end

    // RSTN gates the strobe directly so a reset during ACCESS blocks the write.
    assign MWE   = (state_r == ST_ACCESS) & we_r & RSTN;
    assign MRA   = mra_r;
    assign MWD   = mwd_r;
    assign A_ACK = a_ack_r;
    assign B_ACK = b_ack_r;
    assign A_RD  = a_rd_r;
    assign B_RD  = b_rd_r;

endmodule

// File: tb/tb_mcp_mem_arbiter.sv
// Directed bench for mcp_mem_arbiter: cycle vector table plus reset/abandon sequences.
`timescale 1ns/1ps
module tb_mcp_mem_arbiter;

    logic        CLK;
    logic        RSTN;
    logic        A_REQ, A_WE, A_ACK;
    logic [8:0]  A_ADDR;
    logic [31:0] A_WD, A_RD;
    logic        B_REQ, B_WE, B_ACK;
    logic [8:0]  B_ADDR;
    logic [31:0] B_WD, B_RD;
    logic        MWE;
    logic [8:0]  MRA;
    logic [31:0] MWD, MRD;

    logic [31:0] mem [512];
    logic        pl_en;
    logic [8:0]  pl_addr;
    logic [31:0] pl_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rstn;
        logic        a_req;
        logic        a_we;
        logic [8:0]  a_addr;
        logic [31:0] a_wd;
        logic        b_req;
        logic [8:0]  b_addr;
        logic        e_a_ack;
        logic        e_b_ack;
        logic        e_mwe;
        logic [8:0]  e_mra;
        logic [31:0] e_mwd;
        logic [31:0] e_a_rd;
        logic [31:0] e_b_rd;
    } vec_t;

    vec_t tv[$];

    mcp_mem_arbiter #(.WL(32), .AL(9)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WD(A_WD), .A_ACK(A_ACK), .A_RD(A_RD),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WD(B_WD), .B_ACK(B_ACK), .B_RD(B_RD),
        .MWE(MWE), .MRA(MRA), .MWD(MWD), .MRD(MRD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: asynchronous read, synchronous write, bench-side preload port.
    assign MRD = mem[MRA];
    always @(posedge CLK) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (MWE) mem[MRA] <= MWD;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rstn, input logic a_req, input logic a_we,
                                input logic [8:0] a_addr, input logic [31:0] a_wd,
                                input logic b_req, input logic [8:0] b_addr,
                                input logic aa, input logic ba, input logic mwe,
                                input logic [8:0] mra, input logic [31:0] mwd,
                                input logic [31:0] ard, input logic [31:0] brd);
        vec_t v;
        v.rstn = rstn; v.a_req = a_req; v.a_we = a_we; v.a_addr = a_addr; v.a_wd = a_wd;
        v.b_req = b_req; v.b_addr = b_addr;
        v.e_a_ack = aa; v.e_b_ack = ba; v.e_mwe = mwe; v.e_mra = mra; v.e_mwd = mwd;
        v.e_a_rd = ard; v.e_b_rd = brd;
        return v;
    endfunction

    initial begin
        logic [8:0]  pa [6];
        logic [31:0] pd [6];
        pa[0] = 9'h001; pd[0] = 32'h0000_0011;
        pa[1] = 9'h002; pd[1] = 32'h0000_0022;
        pa[2] = 9'h1FF; pd[2] = 32'hCAFE_F00D;
        pa[3] = 9'h020; pd[3] = 32'hDEAD_BEEF;
        pa[4] = 9'h005; pd[4] = 32'h0000_0055;
        pa[5] = 9'h006; pd[5] = 32'h0000_0066;

        RSTN = 1'b0;
        A_REQ = 1'b0; A_WE = 1'b0; A_ADDR = 9'h000; A_WD = 32'h0;
        B_REQ = 1'b0; B_WE = 1'b0; B_ADDR = 9'h000; B_WD = 32'h0;
        pl_en = 1'b0; pl_addr = 9'h000; pl_data = 32'h0;

        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            pl_en = 1'b1; pl_addr = pa[i]; pl_data = pd[i];
        end
        @(negedge CLK);
        pl_en = 1'b0;

        // Reset with both requests up, then A/B alternation under contention.
        tv.push_back(mk(1'b0, 1'b1, 1'b0, 9'h001, 32'h0, 1'b1, 9'h002, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 32'h0,  32'h0));
        tv.push_back(mk(1'b0, 1'b1, 1'b0, 9'h001, 32'h0, 1'b1, 9'h002, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 32'h0,  32'h0));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 9'h001, 32'h0, 1'b1, 9'h002, 1'b0, 1'b0, 1'b0, 9'h001, 32'h0, 32'h0,  32'h0));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 9'h001, 32'h0, 1'b1, 9'h002, 1'b1, 1'b0, 1'b0, 9'h001, 32'h0, 32'h11, 32'h0));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 9'h001, 32'h0, 1'b1, 9'h002, 1'b0, 1'b0, 1'b0, 9'h001, 32'h0, 32'h11, 32'h0));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 9'h001, 32'h0, 1'b1, 9'h002, 1'b0, 1'b0, 1'b0, 9'h002, 32'h0, 32'h11, 32'h0));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 9'h001, 32'h0, 1'b1, 9'h002, 1'b0, 1'b1, 1'b0, 9'h002, 32'h0, 32'h11, 32'h22));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 9'h001, 32'h0, 1'b1, 9'h002, 1'b0, 1'b0, 1'b0, 9'h002, 32'h0, 32'h11, 32'h22));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 9'h001, 32'h0, 1'b1, 9'h002, 1'b0, 1'b0, 1'b0, 9'h001, 32'h0, 32'h11, 32'h22));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 9'h001, 32'h0, 1'b1, 9'h002, 1'b1, 1'b0, 1'b0, 9'h001, 32'h0, 32'h11, 32'h22));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 9'h001, 32'h0, 1'b1, 9'h002, 1'b0, 1'b0, 1'b0, 9'h001, 32'h0, 32'h11, 32'h22));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 9'h001, 32'h0, 1'b1, 9'h002, 1'b0, 1'b0, 1'b0, 9'h002, 32'h0, 32'h11, 32'h22));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 9'h001, 32'h0, 1'b1, 9'h002, 1'b0, 1'b1, 1'b0, 9'h002, 32'h0, 32'h11, 32'h22));
        tv.push_back(mk(1'b1, 1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h002, 32'h0, 32'h11, 32'h22));
        // A writes 0x12345678 to 0x010 then reads it back.
        tv.push_back(mk(1'b1, 1'b1, 1'b1, 9'h010, 32'h12345678, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 9'h010, 32'h12345678, 32'h11, 32'h22));
        tv.push_back(mk(1'b1, 1'b1, 1'b1, 9'h010, 32'h12345678, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 9'h010, 32'h12345678, 32'h11, 32'h22));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h010, 32'h12345678, 32'h11, 32'h22));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h010, 32'h0, 32'h11, 32'h22));
        tv.push_back(mk(1'b1, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 9'h010, 32'h0, 32'h12345678, 32'h22));
        tv.push_back(mk(1'b1, 1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h010, 32'h0, 32'h12345678, 32'h22));
        // B reads the top address.
        tv.push_back(mk(1'b1, 1'b0, 1'b0, 9'h000, 32'h0, 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0, 9'h1FF, 32'h0, 32'h12345678, 32'h22));
        tv.push_back(mk(1'b1, 1'b0, 1'b0, 9'h000, 32'h0, 1'b1, 9'h1FF, 1'b0, 1'b1, 1'b0, 9'h1FF, 32'h0, 32'h12345678, 32'hCAFEF00D));
        tv.push_back(mk(1'b1, 1'b0, 1'b0, 9'h000, 32'h0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h1FF, 32'h0, 32'h12345678, 32'hCAFEF00D));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge CLK);
            RSTN = tv[i].rstn;
            A_REQ = tv[i].a_req; A_WE = tv[i].a_we; A_ADDR = tv[i].a_addr; A_WD = tv[i].a_wd;
            B_REQ = tv[i].b_req; B_WE = 1'b0; B_ADDR = tv[i].b_addr; B_WD = 32'h0;
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_a_ack", i), 32'(A_ACK), 32'(tv[i].e_a_ack));
            chk($sformatf("v%0d_b_ack", i), 32'(B_ACK), 32'(tv[i].e_b_ack));
            chk($sformatf("v%0d_mwe", i),   32'(MWE),   32'(tv[i].e_mwe));
            chk($sformatf("v%0d_mra", i),   32'(MRA),   32'(tv[i].e_mra));
            chk($sformatf("v%0d_mwd", i),   MWD,        tv[i].e_mwd);
            chk($sformatf("v%0d_a_rd", i),  A_RD,       tv[i].e_a_rd);
            chk($sformatf("v%0d_b_rd", i),  B_RD,       tv[i].e_b_rd);
        end

        // Reset asserted during a write ACCESS must block the write and the ACK.
        @(negedge CLK);
        A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 9'h020; A_WD = 32'hAAAAAAAA;
        @(posedge CLK); #1;
        chk("t5_access_mwe", 32'(MWE), 32'd1);
        chk("t5_access_mra", 32'(MRA), 32'h020);
        @(negedge CLK);
        RSTN = 1'b0;
        #1;
        chk("t5_mwe_gated", 32'(MWE), 32'd0);
        @(posedge CLK); #1;
        chk("t5_rst_a_ack", 32'(A_ACK), 32'd0);
        chk("t5_rst_mwe", 32'(MWE), 32'd0);
        chk("t5_rst_mra", 32'(MRA), 32'h000);
        chk("t5_rst_a_rd", A_RD, 32'h0);
        chk("t5_rst_b_rd", B_RD, 32'h0);
        @(negedge CLK);
        RSTN = 1'b1; A_REQ = 1'b0; A_WE = 1'b0; A_WD = 32'h0;
        @(posedge CLK); #1;
        chk("t5_post_a_ack", 32'(A_ACK), 32'd0);
        chk("t5_mem_kept", mem[9'h020], 32'hDEADBEEF);
        @(negedge CLK);
        A_REQ = 1'b1; A_ADDR = 9'h020;
        @(posedge CLK); #1;
        chk("t5_rd_mra", 32'(MRA), 32'h020);
        @(posedge CLK); #1;
        chk("t5_rd_a_ack", 32'(A_ACK), 32'd1);
        chk("t5_rd_a_rd", A_RD, 32'hDEADBEEF);
        @(negedge CLK);
        A_REQ = 1'b0;
        @(posedge CLK); #1;
        chk("t5_rd_ack_end", 32'(A_ACK), 32'd0);

        // Request dropped and address changed after the grant edge.
        @(negedge CLK);
        A_REQ = 1'b1; A_ADDR = 9'h005;
        @(posedge CLK); #1;
        chk("t6_grant_mra", 32'(MRA), 32'h005);
        @(negedge CLK);
        A_REQ = 1'b0; A_ADDR = 9'h006;
        #1;
        chk("t6_access_mra", 32'(MRA), 32'h005);
        chk("t6_access_mwe", 32'(MWE), 32'd0);
        @(posedge CLK); #1;
        chk("t6_a_ack", 32'(A_ACK), 32'd1);
        chk("t6_a_rd", A_RD, 32'h55);
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            chk($sformatf("t6_idle%0d_a_ack", k), 32'(A_ACK), 32'd0);
            chk($sformatf("t6_idle%0d_b_ack", k), 32'(B_ACK), 32'd0);
            chk($sformatf("t6_idle%0d_mra", k), 32'(MRA), 32'h005);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcp_mem_arbiter.md
Name: mcp_mem_arbiter

Overview:
- Two-requester, round-robin arbiter and sequencer in front of the unified MCP memory (async read, sync write, single port).
- Port A is the processor's multicycle memory interface. Port B is the debug/program-loader interface.
- Each granted request becomes one fixed three-state access: latch, access, respond. Read data is registered per port.

Parameters:
- WL, 32, data word width (matches memory WL).
- AL, 9, memory address width (matches memory AL; 2**AL words).

Ports:
- CLK  in  1  system clock, rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- A_REQ  in  1  port A request; held high until A_ACK.
- A_WE  in  1  port A write (1) / read (0).
- A_ADDR  in  AL  port A word address.
- A_WD  in  WL  port A write data.
- A_ACK  out  1  port A one-cycle completion pulse.
- A_RD  out  WL  port A registered read data.
- B_REQ, B_WE, B_ADDR, B_WD, B_ACK, B_RD: same as port A, for port B.
- MWE  out  1  memory write enable.
- MRA  out  AL  memory address.
- MWD  out  WL  memory write data.
- MRD  in  WL  memory read data (combinational from MRA).

Behaviour:
- Clock and reset: one clock CLK. Reset is synchronous and active-low. RSTN is sampled at the rising edge of CLK.
- Reset values: state IDLE; A_ACK=0, B_ACK=0; A_RD=0, B_RD=0; MRA=0, MWD=0; latched WE=0; LAST_GNT=B, so A wins the first tie.
- MWE = (state==ACCESS) & latched_WE & RSTN. Because it is gated combinationally by RSTN, reset asserted during ACCESS suppresses the write at that edge.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If exactly one REQ is high, grant it.
  - If both are high, grant the port that is not LAST_GNT.
  - On grant, at the edge: latch WE/ADDR/WD into the MRA/MWD/WE registers, record the owner, set LAST_GNT=owner, go to ACCESS.
  - With no REQ, stay in IDLE. MRA/MWD hold their last values.
- ACCESS (exactly 1 cycle):
  - MRA/MWD/MWE driven from the latched registers.
  - At the closing edge: a write commits in memory; on a read, owner's RD <= MRD.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - Owner's ACK=1, other ACK=0. Go to IDLE.
  - No new request is sampled in RESP.
- Latency: REQ sampled at edge k → ACCESS during cycle k+1 → ACK high during cycle k+2. Read data is valid on RD in the same cycle ACK is high and is held until the owner's next read.
- Throughput: at most one access per 3 cycles.
- Back-to-back requests: a requester that keeps REQ high through the ACK cycle is treated as issuing a new request at the next IDLE edge.
- Contention: with both REQ continuously high, grants alternate A,B,A,B…
- Writes leave the owner's RD unchanged.
- Dropping REQ after grant: the latched transaction still completes and ACK still pulses. Changes to ADDR/WD/WE after the grant edge are ignored.
- Addresses are used as given (0 … 2**AL−1). No range checking is done and no wrap logic is needed.
- Reset mid-operation (ACCESS or RESP): next state IDLE, no write committed, no ACK issued, RD registers cleared, LAST_GNT=B.
- Never: ACK on both ports in the same cycle; ACK outside RESP; MWE high outside ACCESS.

Test Plan:
1. RSTN low 2 cycles with both REQ high → all outputs 0 throughout, first grant after release goes to A.
2. A writes 0x12345678 to 0x010, then A reads 0x010 → MWE high exactly 1 cycle (MRA=0x010), A_ACK 2 cycles after each REQ sample, A_RD=0x12345678 on the read ACK, B_ACK stays 0.
3. A and B REQ held high continuously, A addr 0x001 / B addr 0x002 reads (preloaded 0x11, 0x22) → ACK order A,B,A,B, one ACK every 3 cycles, A_RD=0x11, B_RD=0x22.
4. B reads top address 0x1FF (preloaded 0xCAFEF00D) → MRA=0x1FF during ACCESS, B_RD=0xCAFEF00D with B_ACK, A_RD unchanged.
5. 0x020 holds 0xDEADBEEF; A writes 0xAAAAAAAA to 0x020 and RSTN goes low during ACCESS → MWE stays 0, no A_ACK, subsequent A read of 0x020 returns 0xDEADBEEF.
6. A issues a read of 0x005; A_REQ drops and A_ADDR changes to 0x006 during ACCESS → access still uses 0x005, A_ACK pulses once, then IDLE with no further grant.
